// File: rtl/aesl_deadlock_pkg.sv
// Shared types and helpers for the deadlock aggregator.
//   state_t        : aggregator FSM state, 2-bit encoding
//   DEFAULT_THRESH : default persistence threshold in cycles
//   lsb_index()    : index of the lowest set bit of a 32-bit vector (0 if none)
package aesl_deadlock_pkg;

    localparam int unsigned DEFAULT_THRESH = 8;

    typedef enum logic [1:0] {
        S_RUN     = 2'd0,
        S_SUSPECT = 2'd1,
        S_REPORT  = 2'd2,
        S_DONE    = 2'd3
    } state_t;

    // Scan from the top so the last hit is the lowest set bit.
    function automatic logic [4:0] lsb_index(input logic [31:0] vec);
        logic [4:0] idx;
        idx = 5'd0;
        for (int i = 31; i >= 0; i--) begin
            if (vec[i]) begin
                idx = 5'(i);
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/aesl_deadlock_lsb_enc.sv
// Combinational priority encoder: lowest set bit of vec.
//   vec : NUM_MON-bit input vector
//   idx : index of the lowest set bit (0 when vec is zero)
//   any : vec has at least one bit set
module aesl_deadlock_lsb_enc
    import aesl_deadlock_pkg::*;
#(
    parameter int unsigned NUM_MON = 4
) (
    input  logic [NUM_MON-1:0]         vec,
    output logic [$clog2(NUM_MON)-1:0] idx,
    output logic                       any
);

    localparam int unsigned IDX_W = $clog2(NUM_MON);

    always_comb begin
        idx = IDX_W'(lsb_index(32'(vec)));
        any = |vec;
    end

endmodule

// File: rtl/aesl_deadlock_aggregator.sv
// Aggregates per-instance deadlock monitor flags, confirms a deadlock after a
// stable blocked pattern persists THRESH cycles, and issues one report over a
// valid/ready handshake.
// Optional build macro: AESL_DEADLOCK_TIMESTAMP_EN adds report_cycle, the
// free-running cycle count captured at confirmation.
//   clock, reset       : clock, asynchronous active-high reset
//   block_sigs         : per-monitor block flags
//   idle_sigs          : per-instance idle flags
//   clear              : single-cycle pulse, rearms the detector
//   deadlock_found     : sticky confirmed-deadlock flag
//   report_valid/ready : report handshake
//   report_mask        : block_sigs snapshot at confirmation
//   report_first_idx   : lowest set index in report_mask
//   suspect_cnt        : current persistence count (debug)
module aesl_deadlock_aggregator
    import aesl_deadlock_pkg::*;
#(
    parameter int unsigned NUM_MON = 4,
    parameter int unsigned THRESH  = DEFAULT_THRESH,
    parameter int unsigned CNT_W   = 16
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic [NUM_MON-1:0]         block_sigs,
    input  logic [NUM_MON-1:0]         idle_sigs,
    input  logic                       clear,
    output logic                       deadlock_found,
    output logic                       report_valid,
    input  logic                       report_ready,
    output logic [NUM_MON-1:0]         report_mask,
    output logic [$clog2(NUM_MON)-1:0] report_first_idx,
`ifdef AESL_DEADLOCK_TIMESTAMP_EN
    output logic [31:0]                report_cycle,
`endif
    output logic [CNT_W-1:0]           suspect_cnt
);

    localparam int unsigned IDX_W = $clog2(NUM_MON);

    if (NUM_MON < 2 || NUM_MON > 32) begin : g_bad_num_mon
        $error("NUM_MON must be in 2..32");
    end
    if (THRESH < 2) begin : g_bad_thresh
        $error("THRESH must be >= 2");
    end
    if (CNT_W < 31 && (2 ** CNT_W) <= THRESH) begin : g_bad_cnt_w
        $error("CNT_W too narrow for THRESH");
    end

    state_t             state;
    logic [NUM_MON-1:0] snap;
    logic               cond_c;
    logic [IDX_W-1:0]   enc_idx_c;
    logic               enc_any_c;

    // At least one monitor blocked and every non-blocked instance idle.
    assign cond_c = (|block_sigs) & (&(block_sigs | idle_sigs));

    aesl_deadlock_lsb_enc #(.NUM_MON(NUM_MON)) u_lsb_enc (
        .vec (snap),
        .idx (enc_idx_c),
        .any (enc_any_c)
    );

`ifdef AESL_DEADLOCK_TIMESTAMP_EN
    logic [31:0] cycle_cnt;

    // Free-running cycle counter; only reset clears it, wraps silently.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cycle_cnt <= 32'd0;
        end else begin
            cycle_cnt <= cycle_cnt + 32'd1;
        end
    end
`endif

    // Detector FSM; clear outranks confirmation and the handshake.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state            <= S_RUN;
            snap             <= '0;
            suspect_cnt      <= '0;
            report_mask      <= '0;
            report_first_idx <= '0;
            report_valid     <= 1'b0;
            deadlock_found   <= 1'b0;
`ifdef AESL_DEADLOCK_TIMESTAMP_EN
            report_cycle     <= 32'd0;
`endif
        end else if (clear) begin
            state            <= S_RUN;
            snap             <= '0;
            suspect_cnt      <= '0;
            report_mask      <= '0;
            report_first_idx <= '0;
            report_valid     <= 1'b0;
            deadlock_found   <= 1'b0;
`ifdef AESL_DEADLOCK_TIMESTAMP_EN
            report_cycle     <= 32'd0;
`endif
        end else begin
            case (state)
                S_RUN: begin
                    suspect_cnt <= '0;
                    if (cond_c) begin
                        snap        <= block_sigs;
                        suspect_cnt <= CNT_W'(1);
                        state       <= S_SUSPECT;
                    end
                end
                S_SUSPECT: begin
                    if (!cond_c) begin
                        suspect_cnt <= '0;
                        state       <= S_RUN;
                    end else if (block_sigs != snap) begin
                        // Pattern moved: restart persistence on the new one.
                        snap        <= block_sigs;
                        suspect_cnt <= CNT_W'(1);
                    end else if (suspect_cnt == CNT_W'(THRESH - 1)) begin
                        suspect_cnt      <= '0;
                        report_mask      <= snap;
                        report_first_idx <= enc_any_c ? enc_idx_c : '0;
                        deadlock_found   <= 1'b1;
                        report_valid     <= 1'b1;
                        state            <= S_REPORT;
`ifdef AESL_DEADLOCK_TIMESTAMP_EN
                        report_cycle     <= cycle_cnt;
`endif
                    end else begin
                        suspect_cnt <= suspect_cnt + CNT_W'(1);
                    end
                end
                S_REPORT: begin
                    if (report_ready) begin
                        report_valid <= 1'b0;
                        state        <= S_DONE;
                    end
                end
                S_DONE: begin
                    // Terminal until clear; inputs ignored.
                end
                default: begin
                    state <= S_RUN;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_aesl_deadlock_aggregator.sv
// Scoreboard bench for aesl_deadlock_aggregator (NUM_MON=4, THRESH=8).
// The stimulus process pushes expected reports; a negedge monitor pops and
// compares each one when report_valid rises and checks it stays stable.
module tb_aesl_deadlock_aggregator;

    localparam int unsigned NUM_MON = 4;
    localparam int unsigned THRESH  = 8;
    localparam int unsigned CNT_W   = 16;

    logic             clock = 1'b0;
    logic             reset;
    logic [3:0]       block_sigs;
    logic [3:0]       idle_sigs;
    logic             clear;
    logic             deadlock_found;
    logic             report_valid;
    logic             report_ready;
    logic [3:0]       report_mask;
    logic [1:0]       report_first_idx;
    logic [CNT_W-1:0] suspect_cnt;
`ifdef AESL_DEADLOCK_TIMESTAMP_EN
    logic [31:0]      report_cycle;
    int               ts = 0;
`endif

    aesl_deadlock_aggregator #(
        .NUM_MON(NUM_MON), .THRESH(THRESH), .CNT_W(CNT_W)
    ) dut (
        .clock            (clock),
        .reset            (reset),
        .block_sigs       (block_sigs),
        .idle_sigs        (idle_sigs),
        .clear            (clear),
        .deadlock_found   (deadlock_found),
        .report_valid     (report_valid),
        .report_ready     (report_ready),
        .report_mask      (report_mask),
        .report_first_idx (report_first_idx),
`ifdef AESL_DEADLOCK_TIMESTAMP_EN
        .report_cycle     (report_cycle),
`endif
        .suspect_cnt      (suspect_cnt)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [3:0] mask;
        logic [1:0] idx;
        int         cyc;
    } exp_t;

    exp_t q[$];
    exp_t e;
    int   cyc = 0;
    int   n_chk = 0;
    int   n_pass = 0;
    bit   prev_valid = 1'b0;
    logic [3:0] held_mask;
    logic [1:0] held_idx;

    always @(posedge clock) cyc <= cyc + 1;

`ifdef AESL_DEADLOCK_TIMESTAMP_EN
    always @(posedge clock or posedge reset) begin
        if (reset) ts <= 0;
        else       ts <= ts + 1;
    end
`endif

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    endtask

    task automatic step(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic apply(input logic [3:0] b, input logic [3:0] i);
        block_sigs = b;
        idle_sigs  = i;
    endtask

    task automatic push_exp(input logic [3:0] m, input logic [1:0] ix, input int c);
        exp_t x;
        x.mask = m;
        x.idx  = ix;
        x.cyc  = c;
        q.push_back(x);
    endtask

    task automatic wait_valid(input int max_cycles);
        bit got;
        got = 1'b0;
        for (int i = 0; i < max_cycles; i++) begin
            step();
            if (report_valid) begin
                got = 1'b1;
                break;
            end
        end
        chk("wait_valid", 32'(got), 32'd1);
    endtask

    task automatic do_clear();
        apply(4'b0000, 4'b0000);
        report_ready = 1'b0;
        clear = 1'b1;
        step();
        clear = 1'b0;
        chk("clear_found", 32'(deadlock_found), 32'd0);
        chk("clear_valid", 32'(report_valid), 32'd0);
        chk("clear_mask",  32'(report_mask), 32'd0);
        chk("clear_idx",   32'(report_first_idx), 32'd0);
        chk("clear_cnt",   32'(suspect_cnt), 32'd0);
    endtask

    // Monitor: check each new report against the scoreboard, then stability.
    always @(negedge clock) begin
        if (report_valid) begin
            if (!prev_valid) begin
                if (q.size() == 0) begin
                    n_chk++;
                    $display("FAIL unexpected_report: mask %b at cycle %0d, none expected", report_mask, cyc);
                end else begin
                    e = q.pop_front();
                    chk("rep_mask",  32'(report_mask), 32'(e.mask));
                    chk("rep_idx",   32'(report_first_idx), 32'(e.idx));
                    chk("rep_cycle", 32'(cyc), 32'(e.cyc));
                    chk("rep_found", 32'(deadlock_found), 32'd1);
`ifdef AESL_DEADLOCK_TIMESTAMP_EN
                    chk("rep_timestamp", report_cycle, 32'(ts - 1));
`endif
                end
                held_mask = report_mask;
                held_idx  = report_first_idx;
            end else begin
                chk("hold_mask", 32'(report_mask), 32'(held_mask));
                chk("hold_idx",  32'(report_first_idx), 32'(held_idx));
            end
        end
        prev_valid = report_valid;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation still running at %0t", $time);
        $fatal(1, "timeout");
    end

    initial begin
        int t;
        reset = 1'b1;
        clear = 1'b0;
        report_ready = 1'b0;
        apply(4'b0000, 4'b0000);
        #1;
        chk("rst_valid", 32'(report_valid), 32'd0);
        chk("rst_found", 32'(deadlock_found), 32'd0);
        chk("rst_cnt",   32'(suspect_cnt), 32'd0);
        step(3);
        reset = 1'b0;
        step(2);

        // All-idle never qualifies.
        apply(4'b0000, 4'b1111);
        step(3);
        chk("all_idle_cnt", 32'(suspect_cnt), 32'd0);

        // Basic confirmation and handshake.
        t = cyc;
        apply(4'b0110, 4'b1001);
        push_exp(4'b0110, 2'd1, t + 8);
        wait_valid(20);
        report_ready = 1'b1;
        step();
        report_ready = 1'b0;
        chk("t1_valid_drop", 32'(report_valid), 32'd0);
        chk("t1_found_held", 32'(deadlock_found), 32'd1);
        do_clear();

        // Interrupted persistence, then restore.
        t = cyc;
        apply(4'b0110, 4'b1001);
        step(3);
        chk("t2_cnt3", 32'(suspect_cnt), 32'd3);
        step();
        apply(4'b0110, 4'b1000);
        step(5);
        chk("t2_cnt_cleared", 32'(suspect_cnt), 32'd0);
        chk("t2_no_valid", 32'(report_valid), 32'd0);
        step();
        apply(4'b0110, 4'b1001);
        push_exp(4'b0110, 2'd1, t + 10 + 8);
        wait_valid(20);
        report_ready = 1'b1;
        step();
        report_ready = 1'b0;
        do_clear();

        // Pattern change restarts the count; then backpressure and S_DONE.
        t = cyc;
        apply(4'b0110, 4'b1001);
        step(3);
        apply(4'b0100, 4'b1011);
        push_exp(4'b0100, 2'd2, t + 3 + 8);
        step();
        chk("t3_restart_cnt", 32'(suspect_cnt), 32'd1);
        wait_valid(20);
        apply(4'b0011, 4'b1100);
        step(5);
        report_ready = 1'b1;
        step();
        report_ready = 1'b0;
        chk("t4_valid_drop", 32'(report_valid), 32'd0);
        chk("t4_found_held", 32'(deadlock_found), 32'd1);
        chk("t4_mask_held",  32'(report_mask), 32'b0100);
        apply(4'b0001, 4'b1110);
        step(12);
        chk("t4_no_second", 32'(report_valid), 32'd0);
        do_clear();

        // clear beats the handshake in the same cycle.
        apply(4'b0010, 4'b1101);
        push_exp(4'b0010, 2'd1, cyc + 8);
        wait_valid(20);
        clear = 1'b1;
        report_ready = 1'b1;
        step();
        clear = 1'b0;
        report_ready = 1'b0;
        chk("t5_valid", 32'(report_valid), 32'd0);
        chk("t5_found", 32'(deadlock_found), 32'd0);
        chk("t5_mask",  32'(report_mask), 32'd0);
        apply(4'b1000, 4'b0111);
        push_exp(4'b1000, 2'd3, cyc + 8);
        wait_valid(20);
        report_ready = 1'b1;
        step();
        report_ready = 1'b0;
        do_clear();

        // Asynchronous reset mid-suspect.
        apply(4'b0110, 4'b1001);
        step(5);
        chk("t6_cnt5", 32'(suspect_cnt), 32'd5);
        #2;
        reset = 1'b1;
        #1;
        chk("t6_async_cnt",   32'(suspect_cnt), 32'd0);
        chk("t6_async_valid", 32'(report_valid), 32'd0);
        chk("t6_async_found", 32'(deadlock_found), 32'd0);
        chk("t6_async_mask",  32'(report_mask), 32'd0);
        step(2);
        apply(4'b0000, 4'b0000);
        reset = 1'b0;
        step(3);

        chk("queue_empty", 32'(q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
